// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - 16-bit add/subtract, one nibble per cycle through a 4-bit CLA slice
module nibble_serial_adder_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        carry;
  logic [15:0] a_lat;
  logic [15:0] b_lat;
  logic [15:0] partial;

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [3:0]  gen;
  logic [3:0]  prop;
  logic [4:0]  cla_c;
  logic [3:0]  nib_sum;
  logic [15:0] full_result;

  // Select the operand nibbles addressed by the current index
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    case (idx)
      2'd0: begin nib_a = a_lat[3:0];   nib_b = b_lat[3:0];   end
      2'd1: begin nib_a = a_lat[7:4];   nib_b = b_lat[7:4];   end
      2'd2: begin nib_a = a_lat[11:8];  nib_b = b_lat[11:8];  end
      default: begin nib_a = a_lat[15:12]; nib_b = b_lat[15:12]; end
    endcase
  end

  // 4-bit carry-lookahead slice; carry-in comes only from the carry register
  always_comb begin
    gen      = nib_a & nib_b;
    prop     = nib_a ^ nib_b;
    cla_c[0] = carry;
    cla_c[1] = gen[0] | (prop[0] & cla_c[0]);
    cla_c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cla_c[0]);
    cla_c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & cla_c[0]);
    cla_c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & cla_c[0]);
    nib_sum  = prop ^ cla_c[3:0];
    // Only meaningful on the last nibble: top nibble is still in flight
    full_result = {nib_sum, partial[11:0]};
  end

  // Controller FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      carry   <= 1'b0;
      a_lat   <= 16'h0000;
      b_lat   <= 16'h0000;
      partial <= 16'h0000;
      sum     <= 16'h0000;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in
            a_lat <= a;
            b_lat <= b ^ {16{sub}};
            carry <= sub;
            idx   <= 2'd0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          case (idx)
            2'd0: partial[3:0]   <= nib_sum;
            2'd1: partial[7:4]   <= nib_sum;
            2'd2: partial[11:8]  <= nib_sum;
            default: partial[15:12] <= nib_sum;
          endcase
          carry <= cla_c[4];
          idx   <= idx + 2'd1;
          if (idx == 2'd3) begin
            sum   <= full_result;
            c_out <= cla_c[4];
            ovf   <= (a_lat[15] == b_lat[15]) && (full_result[15] != a_lat[15]);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 16 bits, processed as 4 nibbles through one 4-bit carry-lookahead adder slice.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  request a new operation; accepted only when ready=1.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 a  input  16  operand A; sampled with start.
REQ-007 b  input  16  operand B; sampled with start.
REQ-008 ready  output  1  high only in IDLE; controller can accept start.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  16  result, held until the next accepted start completes.
REQ-011 c_out  output  1  carry out of bit 15; for sub, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement signed overflow of the 16-bit operation.

Function
REQ-013 FSM states: IDLE, RUN, DONE; exactly one state at a time.
REQ-014 IDLE: ready=1; start=1 at an edge latches a, b^{16{sub}}, and sub, clears nibble index to 0, loads the carry register with sub, and moves to RUN.
REQ-015 IDLE with start=0: remain in IDLE; all outputs hold.
REQ-016 RUN: each cycle, the 4-bit CLA adds latched A nibble[idx], latched B' nibble[idx], and the carry register; at the edge, the nibble sum is written to partial-result bits [4*idx+3:4*idx], CLA carry-out goes to the carry register, and idx increments.
REQ-017 RUN lasts exactly 4 cycles (idx 0..3); the edge processing idx=3 moves to DONE.
REQ-018 That edge also updates the output registers: sum = full partial result, c_out = final CLA carry-out, ovf = (A[15]==B'[15]) && (sum[15]!=A[15]).
REQ-019 DONE: done=1, ready=0 for exactly one cycle; unconditional transition to IDLE.
REQ-020 Latency: start accepted at edge k; done high in the cycle after edge k+4; ready high again after edge k+5.
REQ-021 Throughput: with start held high, a new operation is accepted every 6 cycles.
REQ-022 start while ready=0 (RUN or DONE) is ignored, with no side effects; operand inputs are don't-care outside the accepting edge.
REQ-023 sum, c_out, and ovf do not change during RUN; they change only at the RUN->DONE edge or on reset.
REQ-024 Arithmetic is modulo 2^16; no saturation. Carry between nibbles passes only through the carry register, and the carry chain is exact across all 4 nibbles.

Reset
REQ-025 rst=1 at an edge has priority over all other inputs: state=IDLE, idx=0, carry register=0, partial result=0, sum=0, c_out=0, ovf=0, done=0; ready=1 after that edge.
REQ-026 rst during RUN or DONE aborts the operation; no done pulse is generated for it.
REQ-027 start asserted together with rst is discarded.

Verification
REQ-028 a=0x1234, b=0x4321, sub=0 -> done 4 cycles after accept edge; sum=0x5555, c_out=0, ovf=0; sum unchanged during RUN.
REQ-029 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, c_out=1, ovf=0 (carry through all nibbles).
REQ-030 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, c_out=0, ovf=1.
REQ-031 sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
REQ-032 Pulse start with a=0x0001, b=0x0001 in the second RUN cycle -> ignored; result is that of the original operation, exactly one done pulse. Separately, assert rst in the third RUN cycle -> ready=1 next cycle, no done, sum=0x0000.
REQ-033 start held high for 20 cycles with changing operands -> accepts at cycles 0, 6, 12, 18; each result matches operands sampled at its accept edge; done never asserted while ready=1.
